// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between the CPU (port 0) and a loader (port 1); 0-cycle grant, access N+1, read data N+2.
// Losing requester sees gnt low and holds; loader lock (MEM_PORT_ARB_LOCK_EN) gives port 1 exclusive ownership.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rd,
  output logic          stall0,
  output logic          memValid,
  output logic          memEnable,
  output logic [AW-1:0] memAdr,
  output logic [DW-1:0] memWD,
  input  logic [DW-1:0] memRD
);

  typedef enum logic {RR, LOCK1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   tag_owner, tag_read;
  logic   rv_pend, rv_owner;

`ifndef MEM_PORT_ARB_LOCK_EN
  logic lock1_unused;
  assign lock1_unused = lock1;
`endif

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    last_nxt  = last;
    case (state)
      RR: begin
        // On a tie the port that did not win last time goes first.
        if (req0 && req1) begin
          gnt0 = last;
          gnt1 = ~last;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        if (gnt0)      last_nxt = 1'b0;
        else if (gnt1) last_nxt = 1'b1;
`ifdef MEM_PORT_ARB_LOCK_EN
        if (gnt1 && lock1) state_nxt = LOCK1;
`endif
      end
      LOCK1: begin
        gnt1     = req1;
        last_nxt = 1'b1;
`ifdef MEM_PORT_ARB_LOCK_EN
        if (!lock1) state_nxt = RR;
`else
        state_nxt = RR;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RR;
      last      <= 1'b1;
      memValid  <= 1'b0;
      memEnable <= 1'b0;
      memAdr    <= '0;
      memWD     <= '0;
      tag_owner <= 1'b0;
      tag_read  <= 1'b0;
      rv_pend   <= 1'b0;
      rv_owner  <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      memValid  <= gnt0 | gnt1;
      memEnable <= gnt0 ? we0 : (gnt1 & we1);
      if (gnt0 || gnt1) begin
        memAdr <= gnt1 ? adr1 : adr0;
        memWD  <= gnt1 ? wd1 : wd0;
      end
      tag_owner <= gnt1;
      tag_read  <= gnt0 ? ~we0 : (gnt1 & ~we1);
      // Memory answers one cycle after the access, so the tag is delayed once more.
      rv_pend   <= memValid & tag_read;
      rv_owner  <= tag_owner;
    end
  end

  assign rvalid0 = rv_pend & ~rv_owner;
  assign rvalid1 = rv_pend & rv_owner;
  assign rd      = memRD;
  assign stall0  = req0 & ~gnt0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based reference model checked every cycle plus literal expectations.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1, lock1;
  logic [7:0] adr0, adr1, wd0, wd1;
  logic       gnt0, gnt1, rvalid0, rvalid1, stall0;
  logic [7:0] rd;
  logic       memValid, memEnable;
  logic [7:0] memAdr, memWD, memRD;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rd(rd), .stall0(stall0),
    .memValid(memValid), .memEnable(memEnable), .memAdr(memAdr), .memWD(memWD),
    .memRD(memRD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory behind the port, plus an independent reference copy for the model.
  logic [7:0] mem   [256];
  logic [7:0] ref_m [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i) ^ 8'h5A;
      ref_m[i] = 8'(i) ^ 8'h5A;
    end
    memRD = 8'h00;
  end
  always @(posedge clk) begin
    if (memValid) begin
      if (memEnable) mem[memAdr] <= memWD;
      else           memRD <= mem[memAdr];
    end
  end

  // Reference model: expected bus state after each edge and a queue of pending read returns.
  typedef struct {
    int       due;
    bit       owner;
    bit [7:0] data;
  } rd_t;
  rd_t q[$];
  int  cyc = 0;
  int  last_m = 1;
  bit  locked_m = 1'b0;
  int  e_mv = 0, e_me = 0, e_adr = 0, e_wd = 0;
  int  g0e, g1e, rv0e, rv1e;

  always @(negedge clk) begin
    if (!reset) begin
      last_m = 1; locked_m = 1'b0;
      e_mv = 0; e_me = 0; e_adr = 0; e_wd = 0;
      q.delete();
    end
    g0e = 0; g1e = 0;
    if (locked_m)                g1e = int'(req1);
    else if (req0 && req1) begin
      if (last_m == 1) g0e = 1; else g1e = 1;
    end else begin
      g0e = int'(req0); g1e = int'(req1);
    end
    chk("gnt0", int'(gnt0), g0e);
    chk("gnt1", int'(gnt1), g1e);
    chk("stall0", int'(stall0), int'(req0) & (1 - g0e));
    chk("memValid", int'(memValid), e_mv);
    chk("memEnable", int'(memEnable), e_me);
    chk("memAdr", int'(memAdr), e_adr);
    chk("memWD", int'(memWD), e_wd);
    rv0e = 0; rv1e = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].owner) rv1e = 1; else rv0e = 1;
    end
    chk("rvalid0", int'(rvalid0), rv0e);
    chk("rvalid1", int'(rvalid1), rv1e);
    if (rv0e + rv1e > 0) begin
      chk("rd", int'(rd), int'(q[0].data));
      void'(q.pop_front());
    end
    if (reset) begin
      if (g0e + g1e > 0) begin
        e_mv  = 1;
        e_me  = g1e ? int'(we1) : int'(we0);
        e_adr = g1e ? int'(adr1) : int'(adr0);
        e_wd  = g1e ? int'(wd1) : int'(wd0);
        if (e_me == 1) ref_m[e_adr] = 8'(e_wd);
        else q.push_back('{due: cyc + 2, owner: (g1e == 1), data: ref_m[e_adr]});
        last_m = g1e;
      end else begin
        e_mv = 0; e_me = 0;
      end
`ifdef MEM_PORT_ARB_LOCK_EN
      if (locked_m) begin
        last_m = 1;
        if (!lock1) locked_m = 1'b0;
      end else if (g1e == 1 && lock1) begin
        locked_m = 1'b1;
      end
`endif
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
  endtask

  int exp_lock [7];
  int seen;

  initial begin
`ifdef MEM_PORT_ARB_LOCK_EN
    exp_lock = '{0, 0, 0, 0, 0, 0, 1};
`else
    exp_lock = '{0, 1, 0, 1, 1, 1, 1};
`endif
    reset = 0; idle();
    adr0 = 0; adr1 = 0; wd0 = 0; wd1 = 0;
    step(); step(); step();
    chk("rst_memValid", int'(memValid), 0);
    chk("rst_memEnable", int'(memEnable), 0);
    chk("rst_memAdr", int'(memAdr), 0);
    chk("rst_rvalid", int'(rvalid0 | rvalid1), 0);
    reset = 1;
    step();

    // First tie goes to port 0, then port 1.
    req0 = 1; req1 = 1; adr0 = 8'h10; adr1 = 8'h11;
    #2 chk("tie_first_gnt0", int'(gnt0), 1);
    chk("tie_first_gnt1", int'(gnt1), 0);
    step(); req0 = 0;
    #2 chk("tie_second_gnt1", int'(gnt1), 1);
    step(); idle(); step();

    // Port 1 writes 0x04 to 0x20.
    req1 = 1; we1 = 1; adr1 = 8'h20; wd1 = 8'h04;
    step(); idle();
    #2 chk("wr_memValid", int'(memValid), 1);
    chk("wr_memEnable", int'(memEnable), 1);
    chk("wr_memAdr", int'(memAdr), 8'h20);
    chk("wr_memWD", int'(memWD), 8'h04);
    step(); step();

    // Port 0 reads it back two cycles after its grant.
    req0 = 1; we0 = 0; adr0 = 8'h20;
    #2 chk("rd_gnt0", int'(gnt0), 1);
    step(); idle(); step();
    #2 chk("rd_rvalid0", int'(rvalid0), 1);
    chk("rd_data", int'(rd), 8'h04);
    chk("rd_rvalid1", int'(rvalid1), 0);
    step();

    // A lone port-1 write leaves port 1 as last winner, then 6 cycles of contention.
    req1 = 1; we1 = 1; adr1 = 8'h30; wd1 = 8'h99;
    step(); idle(); step();
    req0 = 1; we0 = 1; adr0 = 8'h60; wd0 = 8'h11;
    req1 = 1; we1 = 1; adr1 = 8'h70; wd1 = 8'h22;
    for (int i = 0; i < 6; i++) begin
      #2 chk($sformatf("alt_gnt0_%0d", i), int'(gnt0), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_stall0_%0d", i), int'(stall0), (i % 2 == 1) ? 1 : 0);
      step();
    end
    idle(); step();

    // Lone port-0 read makes port 1 win the next tie; then lock sequence.
    req0 = 1; we0 = 0; adr0 = 8'h40;
    step(); idle(); step();
    req0 = 1; we0 = 0; adr0 = 8'h40;
    req1 = 1; we1 = 1; adr1 = 8'h50; wd1 = 8'h33; lock1 = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) req1 = 0;
      if (i == 5) lock1 = 0;
      #2 chk($sformatf("lock_gnt0_%0d", i), int'(gnt0), exp_lock[i]);
      step();
    end
    idle(); step(); step(); step();

    // Reset one cycle after a port-0 read grant drops the pending rvalid.
    req0 = 1; we0 = 0; adr0 = 8'h20;
    #2 chk("rst_rd_gnt0", int'(gnt0), 1);
    step(); idle(); reset = 0;
    #1 chk("rst_mid_memValid", int'(memValid), 0);
    chk("rst_mid_memAdr", int'(memAdr), 0);
    chk("rst_mid_memWD", int'(memWD), 0);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rvalid0) seen = 1;
    end
    step(); reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid0) seen = 1;
    end
    chk("rst_no_rvalid0", seen, 0);
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the CPU's single 8-bit memory port between two requesters:
  - port 0: the multicycle CPU core's fetch/load/store path;
  - port 1: a program loader/debug master that fills or inspects memory while the CPU is stalled.
- Arbitrates one access per cycle with round-robin fairness and an optional loader lock.
- Registers the winning access onto the memory bus and routes synchronous read data back to the owning requester.

## Interface

Parameters:
- AW, 8, address width
- DW, 8, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  port requests an access; held with we/adr/wd stable until gnt
- we0 / we1  in  1  1 = write, 0 = read
- adr0 / adr1  in  AW  access address
- wd0 / wd1  in  DW  write data
- lock1  in  1  loader requests exclusive ownership (see Configuration)
- gnt0 / gnt1  out  1  combinational; access accepted at the next rising edge
- rvalid0 / rvalid1  out  1  read data valid on rd this cycle
- rd  out  DW  read data, shared by both ports, qualified by rvalidN
- stall0  out  1  req0 & ~gnt0, fed to the CPU control FSM
- memValid  out  1  registered; memory access presented this cycle
- memEnable  out  1  registered; write strobe (memValid & write)
- memAdr  out  AW  registered address
- memWD  out  DW  registered write data
- memRD  in  DW  memory read data, valid one cycle after memValid

## Operation

- State machine (registered):
  - RR: round-robin between ports.
  - LOCK1: port 1 exclusive owner.
- Round-robin pointer `last` (1 bit):
  - Both requests asserted in RR: grant the port ≠ `last`.
  - Single request: grant it.
  - `last` updates to the granted port.
  - Reset value 1, so port 0 wins the first tie.
- At most one gnt per cycle, never both.
- Granted access is registered onto memValid/memEnable/memAdr/memWD at the edge closing the gnt cycle.
- No grant: memValid=0, memEnable=0; memAdr/memWD hold their last value.
- Read tag: a 1-bit registered owner, plus a registered is_read flag, accompany each access.
  - One cycle after memValid with is_read, rvalidN=1 for the tagged owner.
  - rd = memRD in that same cycle (combinational pass-through).
- Writes produce no rvalid.
- Requester protocol:
  - Requester drops or changes req in the cycle after gnt.
  - A req held high after gnt is a new access.
- Transitions:
  - RR→LOCK1: gnt1 & lock1.
  - LOCK1→RR: ~lock1, sampled at an edge.
  - In LOCK1: gnt1=req1, gnt0=0; `last` is forced to 1 on exit.

## Timing

- Grant latency: 0 cycles; gnt is combinational in the request cycle when the port wins.
- Memory access: cycle N+1 after gnt in cycle N.
- Read data: rvalid/rd in cycle N+2.
- Throughput: one access per cycle sustained; back-to-back alternation when both ports request.
- Reset values (asynchronous, on reset=0):
  - state=RR, last=1.
  - memValid=0, memEnable=0, memAdr=0, memWD=0.
  - Read tag cleared, so rvalid0=rvalid1=0.
- Reset mid-read: the pending rvalid is dropped and never issued.
- lock1 asserted while port 0 holds the current grant: port 0's access completes. LOCK1 is entered only at a later gnt1.
- lock1 with req1=0 in LOCK1: no grants. Port 0 stalls until lock1 falls.
- Max wait for port 0 in RR: 1 cycle.

## Configuration

- MEM_PORT_ARB_LOCK_EN defined:
  - lock1 is honoured and the LOCK1 state exists as described.
- MEM_PORT_ARB_LOCK_EN undefined:
  - lock1 is ignored and the FSM stays permanently in RR.
  - Pure round-robin; lock1 has no effect on any output.

## Test plan

- Reset held low, then released → all mem outputs 0, rvalid 0. First simultaneous req0/req1 grants port 0, next cycle port 1.
- Port 1 writes 0x04 to 0x20 (gnt1 cycle N) → memValid=memEnable=1, memAdr=0x20, memWD=0x04 in N+1. No rvalid.
- Port 0 reads 0x20 with memory returning 0x04 → rvalid0=1, rd=0x04 exactly two cycles after gnt0; rvalid1 stays 0.
- Both ports request continuously for 6 cycles → grants alternate 0,1,0,1,0,1. stall0 is high on port-1 cycles only.
- With MEM_PORT_ARB_LOCK_EN, port 1 holds lock1 over 4 writes while req0=1:
  - gnt0=0 and stall0=1 throughout.
  - Port 0 is granted the cycle after lock1 falls.
  - Without the macro, grants alternate.
- Assert reset low one cycle after a port-0 read gnt → no rvalid0 ever appears; outputs return to reset values immediately.
